// File: rtl/quad_encoder_pkg.sv
// Shared types and the quadrature decode table for the encoder interface.
package quad_encoder_pkg;

  localparam int POS_WIDTH_DEF = 32;

  typedef enum logic {PRIME, RUN} fsm_t;

  // {A, B} sampled pair
  typedef logic [1:0] quad_t;

  typedef struct packed {
    logic signed [1:0] delta;
    logic              illegal;
  } decode_t;

  function automatic decode_t quad_decode(input quad_t prev, input quad_t cur);
    decode_t r;
    r.delta   = 2'sb00;
    r.illegal = 1'b0;
    case ({prev, cur})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: r.delta = 2'sb01;
      4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: r.delta = 2'sb11;
      4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: r.illegal = 1'b1;
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/quad_input_filter.sv
// One encoder pin: 2-FF synchroniser followed by a FILTER_LEN-cycle debounce.
module quad_input_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic prime,
  output logic synced,
  output logic filtered
);

  logic       meta_p0;
  logic       sync_p1;
  logic [7:0] stable_cnt;

  assign synced = sync_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_p0    <= 1'b0;
      sync_p1    <= 1'b0;
      filtered   <= 1'b0;
      stable_cnt <= '0;
    end else begin
      meta_p0 <= raw;
      sync_p1 <= meta_p0;
      // debounce stage: priming bypasses the filter so startup levels are not counted
      if (prime || (sync_p1 == filtered)) begin
        filtered   <= sync_p1;
        stable_cnt <= '0;
      end else if (stable_cnt == 8'(FILTER_LEN - 1)) begin
        filtered   <= sync_p1;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/quad_encoder_interface.sv
// Conditions A/B/I encoder pins into a signed position count with index zeroing,
// index capture, windowed velocity and sticky illegal-transition detection.
module quad_encoder_interface
  import quad_encoder_pkg::*;
#(
  parameter int FILTER_LEN        = 4,
  parameter int VEL_WINDOW_CYCLES = 500_000,
  parameter int POS_WIDTH         = POS_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        A,
  input  logic                        B,
  input  logic                        I,
  input  logic                        invert_dir,
  input  logic                        clear_position,
  input  logic                        index_zero_arm,
  input  logic                        clear_error,
  output logic signed [POS_WIDTH-1:0] position,
  output logic                        direction,
  output logic                        count_pulse,
  output logic signed [POS_WIDTH-1:0] velocity,
  output logic                        velocity_valid,
  output logic signed [POS_WIDTH-1:0] index_pos,
  output logic                        index_seen,
  output logic                        index_zero_armed,
  output logic                        quad_error
);

  localparam int PRIME_LEN = 2 + FILTER_LEN;

  fsm_t                        state;
  logic [8:0]                  prime_cnt;
  logic [31:0]                 win_cnt;
  logic signed [POS_WIDTH-1:0] acc;

  logic  a_sync, b_sync, i_sync;
  logic  a_filt, b_filt, i_filt;
  quad_t prev_ab;
  logic  prev_i;
  logic  priming;

  assign priming = (state == PRIME);

  quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk(clk), .reset(reset), .raw(A), .prime(priming), .synced(a_sync), .filtered(a_filt)
  );
  quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk(clk), .reset(reset), .raw(B), .prime(priming), .synced(b_sync), .filtered(b_filt)
  );
  quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_i (
    .clk(clk), .reset(reset), .raw(I), .prime(priming), .synced(i_sync), .filtered(i_filt)
  );

  decode_t                     dec;
  logic signed [1:0]           delta;
  logic signed [POS_WIDTH-1:0] delta_ext;
  logic                        illegal;
  logic                        index_rise;

  always_comb begin
    dec        = quad_decode(prev_ab, {a_filt, b_filt});
    delta      = 2'sb00;
    illegal    = 1'b0;
    index_rise = 1'b0;
    if (!priming) begin
      delta      = invert_dir ? -dec.delta : dec.delta;
      illegal    = dec.illegal;
      index_rise = i_filt && !prev_i;
    end
    delta_ext = {{(POS_WIDTH-2){delta[1]}}, delta};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= PRIME;
      prime_cnt        <= '0;
      win_cnt          <= 32'(VEL_WINDOW_CYCLES - 1);
      acc              <= '0;
      prev_ab          <= '0;
      prev_i           <= 1'b0;
      position         <= '0;
      direction        <= 1'b0;
      count_pulse      <= 1'b0;
      velocity         <= '0;
      velocity_valid   <= 1'b0;
      index_pos        <= '0;
      index_seen       <= 1'b0;
      index_zero_armed <= 1'b0;
      quad_error       <= 1'b0;
    end else begin
      if (priming) begin
        if (prime_cnt == 9'(PRIME_LEN - 1)) state <= RUN;
        else                                 prime_cnt <= prime_cnt + 9'd1;
      end

      // decode stage: history tracks synced pins while priming so RUN starts with no delta
      prev_ab <= priming ? {a_sync, b_sync} : {a_filt, b_filt};
      prev_i  <= priming ? i_sync : i_filt;

      count_pulse <= (delta != 2'sb00);
      if (delta != 2'sb00) direction <= delta[1];

      if (clear_position)                      position <= '0;
      else if (index_rise && index_zero_armed) position <= '0;
      else                                     position <= position + delta_ext;

      if (index_rise && index_zero_armed) index_zero_armed <= index_zero_arm;
      else if (index_zero_arm)            index_zero_armed <= 1'b1;

      if (index_rise) begin
        index_seen <= 1'b1;
        index_pos  <= position;
      end

      if (illegal)          quad_error <= 1'b1;
      else if (clear_error) quad_error <= 1'b0;

      // velocity window: the closing cycle's delta is folded into the published value
      if (win_cnt == 32'd0) begin
        velocity       <= acc + delta_ext;
        acc            <= '0;
        velocity_valid <= 1'b1;
        win_cnt        <= 32'(VEL_WINDOW_CYCLES - 1);
      end else begin
        acc            <= acc + delta_ext;
        velocity_valid <= 1'b0;
        win_cnt        <= win_cnt - 32'd1;
      end
    end
  end

endmodule

// File: doc/quad_encoder_interface.md
Name: quad_encoder_interface

Overview:
- Upstream stage feeding the stepper position PI loop: conditions raw A/B/I encoder pins and produces a signed position count.
- Chain per pin: 2-FF synchronise, then debounce filter, then quadrature decode.
- Also provides index-referenced zeroing, index position capture, windowed velocity measurement and sticky illegal-transition detection.
- The position output connects directly to the controller's position input.

Parameters:
- FILTER_LEN, 4: consecutive stable cycles required before a filtered input changes (1..255).
- VEL_WINDOW_CYCLES, 500_000: velocity measurement window in clk cycles (2..2^31-1); 10 ms at 50 MHz.
- POS_WIDTH, 32: width of position, index_pos and velocity.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- A  in  1  encoder channel A, asynchronous.
- B  in  1  encoder channel B, asynchronous.
- I  in  1  encoder index, asynchronous.
- invert_dir  in  1  1 = negate count direction.
- clear_position  in  1  one-cycle pulse: position <= 0.
- index_zero_arm  in  1  one-cycle pulse: arm zero-on-next-index.
- clear_error  in  1  one-cycle pulse: clear quad_error.
- position  out  POS_WIDTH  signed position count.
- direction  out  1  direction of the last count (0 = +, 1 = -).
- count_pulse  out  1  one-cycle pulse per counted edge.
- velocity  out  POS_WIDTH  signed counts per window.
- velocity_valid  out  1  one-cycle pulse when velocity updates.
- index_pos  out  POS_WIDTH  position latched at the last index rising edge.
- index_seen  out  1  sticky; set on the first index edge after reset.
- index_zero_armed  out  1  arm status.
- quad_error  out  1  sticky illegal-transition flag.

Behaviour:
- Reset: all outputs 0. Filters, window counter and accumulator cleared. FSM enters PRIME.
- Synchronisation: each pin passes through a 2-FF synchroniser.
- Filter: per-pin counter. The filtered value takes the synced value only after the synced value has differed from it for FILTER_LEN consecutive cycles. Any agreement resets the counter. Pulses shorter than FILTER_LEN cycles are never seen.
- Latency: pin change to position update = 2 + FILTER_LEN + 1 cycles.
- FSM PRIME:
  - Lasts 2 + FILTER_LEN cycles.
  - Filtered A/B/I are loaded directly from the synced values.
  - No counting, no error detection, no index edge detection.
  - Then goes to RUN.
- FSM RUN:
  - Decodes previous vs current filtered {A,B} every cycle.
  - delta = +1 for 00->10, 10->11, 11->01, 01->00.
  - delta = -1 for the reverse transitions.
  - delta = 0 if there is no change.
  - Both bits changing is illegal: delta = 0 and quad_error <= 1.
  - invert_dir negates delta.
- Nonzero delta: count_pulse = 1 that cycle; direction <= (delta < 0).
- Position arithmetic: two's-complement wrap at POS_WIDTH (0x7FFFFFFF + 1 -> 0x80000000); no saturation.
- Position update priority, same cycle:
  1. reset
  2. clear_position -> 0, delta dropped
  3. armed index rising edge -> 0, delta dropped, armed cleared
  4. position + delta
- Index handling:
  - A rising edge of filtered I in RUN sets index_seen <= 1.
  - It also sets index_pos <= the position value before this cycle's update, whether armed or not.
  - index_zero_arm sets armed.
  - If index_zero_arm and an armed index edge coincide, the zeroing happens and armed stays 1.
- quad_error is cleared by clear_error. If an illegal transition occurs in the same cycle, set wins.
- Velocity:
  - Window counter runs from VEL_WINDOW_CYCLES-1 down to 0 in both PRIME and RUN.
  - The accumulator adds delta every cycle; clear_position does not affect it.
  - At counter = 0: velocity <= acc + delta, acc <= 0, velocity_valid = 1 for one cycle, counter reloads.
  - The accumulator cannot overflow given the parameter limits.
- Reset mid-operation: all state returns to reset values on the next clk edge. Counting resumes only after PRIME completes.

Decomposition:
- Shared package quad_encoder_pkg:
  - FSM enum {PRIME, RUN}
  - 2-bit quadrature state typedef
  - decode function returning delta and an illegal flag
  - POS_WIDTH default constant
- Sub-module quad_input_filter: synchroniser plus FILTER_LEN debounce, one bit wide, instantiated three times.

Test Plan:
- Forward run: after PRIME, A/B stepped through 00,10,11,01,00 twice, each level held 10 cycles -> position = 8, 8 count_pulses, direction = 0. Repeat with invert_dir = 1 -> position = -8.
- Glitch rejection: 3-cycle pulse on A with FILTER_LEN = 4 -> no count, position unchanged. 4-cycle pulse -> +1 then -1, position net 0.
- Illegal jump: A/B 00->11 in one cycle -> quad_error = 1, position unchanged. clear_error pulse -> quad_error = 0. Clear and illegal in the same cycle -> stays 1.
- Index zero: position = 37, pulse index_zero_arm, I rising edge -> index_pos = 37, position = 0, armed = 0, index_seen = 1. A second index edge -> position not zeroed.
- Velocity with VEL_WINDOW_CYCLES = 100: 5 forward counts inside one window -> velocity = 5 with a single velocity_valid pulse at the window end. No motion in the next window -> velocity = 0.
- Wrap and reset: position = 0x7FFFFFFF plus one forward count -> 0x80000000. Assert reset mid-motion -> all outputs 0 next cycle, no counts during PRIME.
